// File: rtl/sum_pkg.sv
// -----------------------------------------------------------------------------
// sum_pkg
// Shared definitions for the summation datapath: the lane count of the 8-way
// adder tree and its inverse (sum_splitter), the splitter FSM state type, and
// the largest total that 8 full-scale lanes can produce.
// -----------------------------------------------------------------------------
package sum_pkg;

    localparam int NUM_LANES  = 8;
    localparam int LANE_IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Largest value an 8-lane sum of DATAWIDTH-bit operands can reach,
    // 8*(2^dw-1). Totals above this cannot be split into legal shares.
    function automatic int unsigned max_total(input int unsigned dw);
        return NUM_LANES * ((32'd1 << dw) - 32'd1);
    endfunction

endpackage : sum_pkg

// File: rtl/sum_splitter_share_calc.sv
// -----------------------------------------------------------------------------
// share_calc
// Combinational share generator for sum_splitter.
//   share_k = q + (k < r), remainder units going to the lowest indices.
//   If the total was saturated (or q+1 would overflow), the share clamps to
//   all ones.
// Ports:
//   i_q     quotient total>>3, one bit wider than a share
//   i_r     remainder total[2:0]
//   i_idx   share index 0..7
//   i_sat   total exceeded the representable maximum
//   o_share resulting DATAWIDTH-bit share
// -----------------------------------------------------------------------------
module share_calc
    import sum_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH:0]      i_q,
    input  logic [LANE_IDX_W-1:0]   i_r,
    input  logic [LANE_IDX_W-1:0]   i_idx,
    input  logic                    i_sat,
    output logic [DATAWIDTH-1:0]    o_share
);

    logic               w_bump;
    logic [DATAWIDTH:0] w_sum;

    assign w_bump = (i_idx < i_r);
    assign w_sum  = i_q + {{DATAWIDTH{1'b0}}, w_bump};

    // The extra top bit of w_sum only gets set when the total was above the
    // maximum, so it acts as a second saturation detector.
    always_comb begin
        if (i_sat || w_sum[DATAWIDTH]) begin
            o_share = '1;
        end else begin
            o_share = w_sum[DATAWIDTH-1:0];
        end
    end

endmodule : share_calc

// File: rtl/sum_splitter.sv
// -----------------------------------------------------------------------------
// sum_splitter
// Inverse of the 8-way adder tree. A DATAWIDTH+3 bit total is accepted in
// IDLE. It is then streamed out as 8 near-equal DATAWIDTH-bit shares, one per
// out_valid/out_ready handshake. Unless the total saturates, the shares sum
// exactly to the total.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_total/valid    total to split (sampled on in_valid && in_ready)
//   in_ready          high only in IDLE
//   out_share         registered share value
//   out_index         share number 0..7
//   out_last          high with share 7
//   out_valid         share stream valid
//   out_ready         downstream accepts current share
//   out_sat           total exceeded 8*(2^DATAWIDTH-1), held for the burst
// -----------------------------------------------------------------------------
module sum_splitter
    import sum_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATAWIDTH+2:0]    in_total,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATAWIDTH-1:0]    out_share,
    output logic [LANE_IDX_W-1:0]   out_index,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat
);

    localparam int              TW      = DATAWIDTH + 3;
    localparam logic [TW-1:0]   MAX_TOT = TW'(max_total(DATAWIDTH));
    localparam logic [LANE_IDX_W-1:0] LAST_IDX = LANE_IDX_W'(NUM_LANES - 1);

    // State and burst context
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATAWIDTH:0]     r_q;
    logic [DATAWIDTH:0]     w_q_nxt;
    logic [LANE_IDX_W-1:0]  r_r;
    logic [LANE_IDX_W-1:0]  w_r_nxt;
    logic [LANE_IDX_W-1:0]  r_idx;
    logic [LANE_IDX_W-1:0]  w_idx_nxt;
    logic                   r_sat;
    logic                   w_sat_nxt;
    logic                   r_last;
    logic                   w_last_nxt;
    logic [DATAWIDTH-1:0]   r_share;
    logic [DATAWIDTH-1:0]   w_share_nxt;
    logic [DATAWIDTH-1:0]   w_share_calc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and burst-context logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_idx_nxt   = r_idx;
        w_sat_nxt   = r_sat;

        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_q_nxt     = {1'b0, in_total[TW-1:3]};
                    w_r_nxt     = in_total[2:0];
                    w_sat_nxt   = (in_total > MAX_TOT);
                    w_idx_nxt   = '0;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (r_idx == LAST_IDX) begin
                        // Burst finished: clear the context so the idle
                        // outputs look the same as after reset.
                        w_q_nxt     = '0;
                        w_r_nxt     = '0;
                        w_idx_nxt   = '0;
                        w_sat_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_idx + LANE_IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The share is computed from the next-cycle context. This lets the output
    // register hold exactly the share that goes with the registered index.
    share_calc #(
        .DATAWIDTH (DATAWIDTH)
    ) u_share_calc (
        .i_q     (w_q_nxt),
        .i_r     (w_r_nxt),
        .i_idx   (w_idx_nxt),
        .i_sat   (w_sat_nxt),
        .o_share (w_share_calc)
    );

    always_comb begin
        w_share_nxt = '0;
        w_last_nxt  = 1'b0;
        if (w_state_nxt == EMIT) begin
            w_share_nxt = w_share_calc;
            w_last_nxt  = (w_idx_nxt == LAST_IDX);
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= '0;
            r_r     <= '0;
            r_idx   <= '0;
            r_sat   <= 1'b0;
            r_last  <= 1'b0;
            r_share <= '0;
        end else begin
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_idx   <= w_idx_nxt;
            r_sat   <= w_sat_nxt;
            r_last  <= w_last_nxt;
            r_share <= w_share_nxt;
        end
    end

    // Handshake flags come straight from the state register, so in_ready
    // never has a combinational path from out_ready.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == EMIT);
    assign out_share = r_share;
    assign out_index = r_idx;
    assign out_last  = r_last;
    assign out_sat   = r_sat;

    // A stalled share must not change or vanish until it is taken.
    a_hold_stalled: assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_share) && $stable(out_index) &&
             $stable(out_last) && $stable(out_sat))
    );

endmodule : sum_splitter
